// File: rtl/rv_decode_pkg.sv
// Shared opcodes, format encodings and decoded-entry layout for the decode stage.
// ILLEGAL_CHECK_EN adds a per-entry illegal flag to the stored entry.
package rv_decode_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_UNK = 3'd7
  } fmt_e;

  // Field part of a queued entry; pc and imm are appended by the top since their widths are parameters.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_e       fmt;
`ifdef ILLEGAL_CHECK_EN
    logic       illegal;
`endif
  } decoded_t;

  function automatic fmt_e classify(input logic [6:0] opcode, input logic rv64);
    fmt_e f;
    case (opcode)
      OP_REG:                                  f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:     f = FMT_I;
      OP_STORE:                                f = FMT_S;
      OP_BRANCH:                               f = FMT_B;
      OP_LUI, OP_AUIPC:                        f = FMT_U;
      OP_JAL:                                  f = FMT_J;
      OP_REG32:                                f = rv64 ? FMT_R : FMT_UNK;
      OP_IMM32:                                f = rv64 ? FMT_I : FMT_UNK;
      default:                                 f = FMT_UNK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH valid/ready queue with synchronous flush.
// A full queue still accepts a push in a cycle where the head is popped.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count < CW'(DEPTH)) | pop;
  assign push      = in_valid & in_ready;
  assign out_data  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I/RV64I decode stage: field split, format, immediate, queued with valid/ready.
// ILLEGAL_CHECK_EN enables the stored out_illegal flag; otherwise it is tied low.
module instr_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [6:0]             out_opcode,
  output logic [4:0]             out_rd,
  output logic [2:0]             out_funct3,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [6:0]             out_funct7,
  output logic [2:0]             out_fmt,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int DW = PC_W + XLEN + $bits(decoded_t);

  decoded_t          dec;
  decoded_t          head;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm;
  logic [DW-1:0]     fifo_out;

  always_comb begin
    dec        = '0;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];
    dec.fmt    = classify(in_instr[6:0], XLEN == 64);
`ifdef ILLEGAL_CHECK_EN
    dec.illegal = (in_instr[1:0] != 2'b11) || (dec.fmt == FMT_UNK);
`endif
  end

  // Immediates are assembled at 32 bits, then sign-extended from bit 31 to XLEN.
  always_comb begin
    imm32 = '0;
    case (dec.fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'($signed(imm32));
  end

  decode_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, imm, dec}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .count     (count)
  );

  assign {out_pc, out_imm, head} = fifo_out;
  assign out_opcode = head.opcode;
  assign out_rd     = head.rd;
  assign out_funct3 = head.funct3;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_funct7 = head.funct7;
  assign out_fmt    = head.fmt;
`ifdef ILLEGAL_CHECK_EN
  assign out_illegal = head.illegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule
